multiplicador_bcd: RTL and testbench

Sequential binary-to-BCD converter placed directly downstream of the shift-add multiplier. When the multiplier raises `done`, this block captures the product, converts it to packed BCD with a shift-and-add-3 (double dabble) algorithm at one shift per two clocks, and holds the decimal digits for the 7-segment display decoders. It uses the same level handshake as the multiplier, so the multiplier's `done` can drive `start` directly.

---
 rtl/multiplicador_bcd.sv | 141 ++++++++++++++
 tb/tb_multiplicador_bcd.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_bcd.sv
// -----------------------------------------------------------------------------
// multiplicador_bcd
//
// Sequential binary-to-BCD converter that sits after the shift-add multiplier.
// When the multiplier raises its done (wired to i_start), the product is
// captured. It is then converted with the shift-and-add-3 (double dabble)
// algorithm, one shift every two clocks. The packed BCD result is held for the
// 7-segment decoders.
//
// Parameters
//   WIDTH   product width in bits
//   DIGITS  BCD digits; 10**DIGITS must exceed 2**WIDTH - 1
//
// Ports
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_start    conversion request (level, four-phase handshake)
//   i_product  unsigned binary value, sampled only at the capture edge
//   o_bcd      packed BCD result, digit 0 (units) in bits [3:0]
//   o_busy     high while converting (ADD3 / SHIFT)
//   o_done     high in DONE; o_bcd is valid and stable
// -----------------------------------------------------------------------------
module multiplicador_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_product,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD3  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_sreg;
    logic [4*DIGITS-1:0]   r_scratch;
    logic [CW-1:0]         r_cnt;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_busy;
    logic                  r_done;

    logic [4*DIGITS-1:0]   w_scratch_sh;
    logic [WIDTH-1:0]      w_sreg_sh;

    // Add 3 to every digit that is 5 or more. After the following shift, such a
    // digit carries into the next decade instead of going past 9.
    function automatic logic [4*DIGITS-1:0] f_add3(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = v[4*d +: 4] + 4'd3;
            end else begin
                r[4*d +: 4] = v[4*d +: 4];
            end
        end
        return r;
    endfunction

    // One-bit left shift of {scratch, sreg}. The scratch MSB is dropped and a
    // zero enters sreg[0].
    assign w_scratch_sh = {r_scratch[4*DIGITS-2:0], r_sreg[WIDTH-1]};
    assign w_sreg_sh    = {r_sreg[WIDTH-2:0], 1'b0};

    // Conversion FSM. The outputs are registered alongside the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_sreg    <= {WIDTH{1'b0}};
            r_scratch <= {(4*DIGITS){1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_bcd     <= {(4*DIGITS){1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sreg    <= i_product;
                        r_scratch <= {(4*DIGITS){1'b0}};
                        r_cnt     <= CW'(WIDTH);
                        r_state   <= S_ADD3;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end else begin
                        r_busy    <= 1'b0;
                        r_done    <= 1'b0;
                    end
                end
                S_ADD3: begin
                    r_scratch <= f_add3(r_scratch);
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_scratch <= w_scratch_sh;
                    r_sreg    <= w_sreg_sh;
                    r_cnt     <= r_cnt - CW'(1);
                    // The count reaches zero with this shift, so the post-shift
                    // scratch is the final result.
                    if (r_cnt == CW'(1)) begin
                        r_bcd   <= w_scratch_sh;
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_ADD3;
                    end
                end
                S_DONE: begin
                    if (!i_start) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end else begin
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_bcd  = r_bcd;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_multiplicador_bcd.sv
// -----------------------------------------------------------------------------
// tb_multiplicador_bcd
//
// Directed self-checking bench for multiplicador_bcd (WIDTH=8, DIGITS=3).
// Inputs are driven, and outputs sampled, 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_multiplicador_bcd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  product;
    logic [11:0] bcd;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    multiplicador_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_product (product),
        .o_bcd     (bcd),
        .o_busy    (busy),
        .o_done    (done)
    );

    // Clock generation: period 10, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: split the value into hundreds, tens and units.
    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    // Run one full handshake: capture p, wait for done (bounded), then drop start.
    task automatic run_conv(input logic [7:0] p, output logic [11:0] res,
                            output int lat, output logic busy_ok,
                            output logic busy_at_done, output logic done_fell);
        product = p;
        start   = 1'b1;
        @(posedge clk); #1;   // capture edge E
        lat     = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res          = bcd;
        busy_at_done = busy;
        start        = 1'b0;
        @(posedge clk); #1;
        done_fell = (done === 1'b0);
    endtask

    task automatic test_reset();
        int lat;
        // Still inside the power-on reset
        n_checks++;
        if (bcd !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_por: got bcd=%h busy=%b done=%b expected 000/0/0", bcd, busy, done);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        // Convert 99 and hold start so that done stays high
        product = 8'd99;
        start   = 1'b1;
        lat = 0;
        @(posedge clk); #1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (done !== 1'b1 || bcd !== 12'h099) begin
            n_fail++;
            $display("FAIL reset_pre: got done=%b bcd=%h expected 1/099", done, bcd);
        end
        // Assert reset mid-cycle, then check before the next clock edge
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bcd !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_async_bcd: got %h expected 000", bcd);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_flags: got busy=%b done=%b expected 0/0", busy, done);
        end
        start = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_max();
        logic [11:0] res;
        int          lat;
        logic        bok;
        logic        bad;
        logic        dfell;
        run_conv(8'd255, res, lat, bok, bad, dfell);
        n_checks++;
        if (res !== 12'h255) begin
            n_fail++;
            $display("FAIL max_value: got %h expected 255", res);
        end
        n_checks++;
        if (lat !== 16) begin
            n_fail++;
            $display("FAIL max_latency: got %0d expected 16", lat);
        end
        n_checks++;
        if (bok !== 1'b1 || bad !== 1'b0) begin
            n_fail++;
            $display("FAIL max_busy: got during=%b at_done=%b expected 1/0", bok, bad);
        end
        n_checks++;
        if (dfell !== 1'b1) begin
            n_fail++;
            $display("FAIL max_done_fall: got done=%b expected 0", done);
        end
        n_checks++;
        if (bcd !== 12'h255) begin
            n_fail++;
            $display("FAIL max_hold: got %h expected 255", bcd);
        end
    endtask

    task automatic test_boundary();
        logic [7:0]  vin [6]  = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd200};
        logic [11:0] vexp [6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h200};
        logic [11:0] res;
        int          lat;
        logic        bok;
        logic        bad;
        logic        dfell;
        for (int i = 0; i < 6; i++) begin
            run_conv(vin[i], res, lat, bok, bad, dfell);
            n_checks++;
            if (res !== vexp[i] || lat !== 16) begin
                n_fail++;
                $display("FAIL boundary_%0d: got %h lat=%0d expected %h lat=16", vin[i], res, lat, vexp[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [11:0] res;
        int          lat;
        logic        bok;
        logic        bad;
        logic        dfell;
        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), res, lat, bok, bad, dfell);
            n_checks++;
            if (res !== ref_bcd(v)) begin
                n_fail++;
                $display("FAIL exhaustive_%0d: got %h expected %h", v, res, ref_bcd(v));
            end
        end
    endtask

    task automatic test_capture_isolation();
        int   lat;
        logic bok;
        product = 8'd37;
        start   = 1'b1;
        @(posedge clk); #1;   // capture edge E
        lat = 0;
        bok = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) bok = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (lat == 2) product = 8'd142;
            if (lat >= 3 && lat <= 10) start = ~start;   // ends high
        end
        n_checks++;
        if (bcd !== 12'h037) begin
            n_fail++;
            $display("FAIL isolation_value: got %h expected 037", bcd);
        end
        n_checks++;
        if (lat !== 16 || bok !== 1'b1) begin
            n_fail++;
            $display("FAIL isolation_timing: got lat=%0d busy_ok=%b expected 16/1", lat, bok);
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midconv();
        int   lat;
        logic seen200;
        product = 8'd200;
        start   = 1'b1;
        @(posedge clk); #1;   // capture edge E
        repeat (7) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bcd !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midconv_reset: got bcd=%h busy=%b done=%b expected 000/0/0", bcd, busy, done);
        end
        // start is already high when reset releases, so capture is on the first edge
        product = 8'd45;
        start   = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        lat     = 0;
        seen200 = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            if (bcd === 12'h200) seen200 = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (bcd !== 12'h045 || lat !== 16) begin
            n_fail++;
            $display("FAIL midconv_next: got %h lat=%0d expected 045 lat=16", bcd, lat);
        end
        n_checks++;
        if (seen200 !== 1'b0) begin
            n_fail++;
            $display("FAIL midconv_aborted: got 200 on bcd expected never");
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int          opa [2] = '{13, 15};
        int          opb [2] = '{11, 15};
        logic [11:0] vexp [2] = '{12'h143, 12'h225};
        int          lat;
        for (int i = 0; i < 2; i++) begin
            // The multiplier is computing, so its done (our start) is low
            repeat (8) begin
                @(posedge clk); #1;
            end
            product = 8'(opa[i] * opb[i]);
            start   = 1'b1;
            lat = 0;
            @(posedge clk); #1;
            while (done !== 1'b1 && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            n_checks++;
            if (bcd !== vexp[i] || lat !== 16) begin
                n_fail++;
                $display("FAIL chain_%0dx%0d: got %h lat=%0d expected %h lat=16", opa[i], opb[i], bcd, lat, vexp[i]);
            end
            start = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || bcd !== vexp[i]) begin
                n_fail++;
                $display("FAIL chain_release_%0d: got done=%b bcd=%h expected 0/%h", i, done, bcd, vexp[i]);
            end
        end
    endtask

    // Test sequence
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        product  = 8'd0;
        #12;
        test_reset();
        test_max();
        test_boundary();
        test_exhaustive();
        test_capture_isolation();
        test_reset_midconv();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
